// File: rtl/mmio_led_pkg.sv
// Shared constants for the LED/RGB PWM peripheral: register map, channel count
// and channel indices.
package mmio_led_pkg;

    localparam int NUM_CH = 4;

    localparam logic [7:0] LED_DUTY_OFS = 8'h00;
    localparam logic [7:0] R_DUTY_OFS   = 8'h04;
    localparam logic [7:0] G_DUTY_OFS   = 8'h08;
    localparam logic [7:0] B_DUTY_OFS   = 8'h0C;
    localparam logic [7:0] MICROS_OFS   = 8'h10;
    localparam logic [7:0] MILLIS_OFS   = 8'h14;

    typedef enum logic [1:0] {
        CH_LED = 2'd0,
        CH_R   = 2'd1,
        CH_G   = 2'd2,
        CH_B   = 2'd3
    } ch_e;

endpackage

// File: rtl/mmio_led_pwm_channel.sv
// One PWM channel: shadow duty latched at period end, registered compare output
// driven at the configured pin polarity.
module pwm_channel
    import mmio_led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_period_end,
    output logic                o_pin
);

    localparam logic OFF_LVL = (ACTIVE_LOW != 0);

    logic [PWM_BITS-1:0] r_shadow;
    logic                r_pin;
    logic                w_on;

    assign w_on  = (i_pwm_cnt < r_shadow);
    assign o_pin = r_pin;

    // Shadow only moves on the last count so a period is never split between duties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_pin    <= OFF_LVL;
        end else begin
            if (i_period_end) begin
                r_shadow <= i_duty;
            end
            r_pin <= w_on ^ OFF_LVL;
        end
    end

endmodule

// File: rtl/mmio_led_pwm.sv
// Memory-mapped LED/RGB PWM peripheral with free-running microsecond and
// millisecond timers; single-cycle registered load path.
module mmio_led_pwm
    import mmio_led_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic        wen,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        LED,
    output logic        RGB_R,
    output logic        RGB_G,
    output logic        RGB_B
);

    localparam int                TICK_DIV = CLK_HZ / 1000000;
    localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [9:0]        SUB_LAST = 10'd999;
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PWM_BITS-1:0] r_duty [NUM_CH];
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PRE_W-1:0]    r_presc;
    logic [9:0]          r_sub;
    logic [31:0]         r_micros;
    logic [31:0]         r_millis;
    logic [31:0]         r_rdata;
    logic                r_rvalid;

    logic [7:0]          w_addr;
    logic [NUM_CH-1:0]   w_duty_we;
    logic [31:0]         w_rdata_nxt;
    logic                w_period_end;
    logic                w_us_tick;
    logic                w_ms_tick;
    logic [NUM_CH-1:0]   w_pin;
    logic                w_unused;

    // Byte lanes within a word are not decoded; only wmask[0] gates duty stores.
    assign w_addr   = {addr[7:2], 2'b00};
    assign w_unused = &{1'b0, addr[1:0], wmask[3:1], wdata[31:PWM_BITS]};

    assign w_period_end = (r_pwm_cnt == CNT_LAST);
    assign w_us_tick    = (r_presc == PRE_LAST);
    assign w_ms_tick    = w_us_tick && (r_sub == SUB_LAST);

    always_comb begin
        w_duty_we = '0;
        if (wen && wmask[0]) begin
            case (w_addr)
                LED_DUTY_OFS: w_duty_we[CH_LED] = 1'b1;
                R_DUTY_OFS:   w_duty_we[CH_R]   = 1'b1;
                G_DUTY_OFS:   w_duty_we[CH_G]   = 1'b1;
                B_DUTY_OFS:   w_duty_we[CH_B]   = 1'b1;
                default:      w_duty_we = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_duty_we[i]) begin
                    r_duty[i] <= wdata[PWM_BITS-1:0];
                end
            end
        end
    end

    always_comb begin
        w_rdata_nxt = '0;
        case (w_addr)
            LED_DUTY_OFS: w_rdata_nxt = 32'(r_duty[CH_LED]);
            R_DUTY_OFS:   w_rdata_nxt = 32'(r_duty[CH_R]);
            G_DUTY_OFS:   w_rdata_nxt = 32'(r_duty[CH_G]);
            B_DUTY_OFS:   w_rdata_nxt = 32'(r_duty[CH_B]);
            MICROS_OFS:   w_rdata_nxt = r_micros;
            MILLIS_OFS:   w_rdata_nxt = r_millis;
            default:      w_rdata_nxt = '0;
        endcase
    end

    // Load data is captured from pre-edge register state, so a same-cycle
    // store to the same address is not visible until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= ren;
            if (ren) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            r_sub    <= '0;
            r_micros <= '0;
            r_millis <= '0;
        end else begin
            if (w_us_tick) begin
                r_presc  <= '0;
                r_micros <= r_micros + 32'd1;
                r_sub    <= w_ms_tick ? 10'd0 : (r_sub + 10'd1);
            end else begin
                r_presc  <= r_presc + 1'b1;
            end
            if (w_ms_tick) begin
                r_millis <= r_millis + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_duty       (r_duty[g]),
            .i_pwm_cnt    (r_pwm_cnt),
            .i_period_end (w_period_end),
            .o_pin        (w_pin[g])
        );
    end

    assign LED   = w_pin[CH_LED];
    assign RGB_R = w_pin[CH_R];
    assign RGB_G = w_pin[CH_G];
    assign RGB_B = w_pin[CH_B];

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Bench for mmio_led_pwm: register-map vector table, load scoreboard, PWM
// low-time counting per period, timer and reset corner sequences.
module tb_mmio_led_pwm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic        wen = 1'b0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        LED, RGB_R, RGB_G, RGB_B;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic exp_v;
    int lo_cnt [4];

    logic [31:0] sb_q [$];
    logic [7:0]  sb_a [$];
    logic [31:0] mon_e;
    logic [7:0]  mon_a;

    typedef struct {
        logic        wr;
        logic [7:0]  waddr;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    mmio_led_pwm #(.CLK_HZ(12000000), .PWM_BITS(8), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wmask(wmask),
        .wdata(wdata), .ren(ren), .rdata(rdata), .rvalid(rvalid),
        .LED(LED), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
    );

    // Reference time base: clocks since reset release; pwm_cnt == cyc mod 256.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc   <= 0;
            exp_v <= 1'b0;
        end else begin
            cyc   <= cyc + 1;
            exp_v <= ren;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid || exp_v) chk("rvalid", 32'(rvalid), 32'(exp_v));
            if (rvalid) begin
                if (sb_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_a = sb_a.pop_front();
                    chk($sformatf("rdata@%02h", mon_a), rdata, mon_e);
                end
            end
        end
    end

    task automatic do_load(input logic [7:0] a, input logic [31:0] e);
        addr = a;
        ren  = 1'b1;
        sb_q.push_back(e);
        sb_a.push_back(a);
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        addr  = a;
        wmask = m;
        wdata = d;
        wen   = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    function automatic logic [31:0] exp_read0(input logic [7:0] a);
        if (a == 8'h10) return 32'(cyc / 12);
        if (a == 8'h14) return 32'(cyc / 12000);
        return 32'd0;
    endfunction

    task automatic wait_period_start();
        int n = 0;
        @(negedge clk);
        @(negedge clk);
        while ((cyc % 256) != 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if ((cyc % 256) != 1) chk("period_sync_timeout", 32'd0, 32'd1);
    endtask

    // One full period of pin samples; optional store to st_a at sample st_at.
    task automatic measure(input int st_at, input logic [7:0] st_a, input logic [31:0] st_d);
        for (int k = 0; k < 4; k++) lo_cnt[k] = 0;
        for (int i = 0; i < 256; i++) begin
            if (!LED)   lo_cnt[0]++;
            if (!RGB_R) lo_cnt[1]++;
            if (!RGB_G) lo_cnt[2]++;
            if (!RGB_B) lo_cnt[3]++;
            if (i == st_at) begin
                addr = st_a; wmask = 4'h1; wdata = st_d; wen = 1'b1;
            end else begin
                wen = 1'b0;
            end
            @(negedge clk);
        end
        wen = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_cyc_%0d", target), 32'(cyc), 32'(target));
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h00, 4'h1, 32'h0000_0011, 8'h00, 32'h0000_0011};
        tbl[1] = '{1'b1, 8'h04, 4'h1, 32'h0000_0080, 8'h04, 32'h0000_0080};
        tbl[2] = '{1'b0, 8'h00, 4'h0, 32'h0000_0000, 8'h07, 32'h0000_0080};
        tbl[3] = '{1'b1, 8'h08, 4'h0, 32'h0000_0055, 8'h08, 32'h0000_0000};
        tbl[4] = '{1'b1, 8'h08, 4'hE, 32'h0000_0066, 8'h08, 32'h0000_0000};
        tbl[5] = '{1'b1, 8'h0C, 4'h1, 32'h1234_56FF, 8'h0C, 32'h0000_00FF};
        tbl[6] = '{1'b1, 8'h18, 4'h1, 32'h0000_00AB, 8'h18, 32'h0000_0000};
        tbl[7] = '{1'b1, 8'hFC, 4'hF, 32'hFFFF_FFFF, 8'hFC, 32'h0000_0000};
        tbl[8] = '{1'b1, 8'h00, 4'h1, 32'h0000_0000, 8'h00, 32'h0000_0000};

        repeat (3) @(negedge clk);
        chk("reset_pins", 32'({LED, RGB_R, RGB_G, RGB_B}), 32'hF);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;

        for (int a = 0; a <= 'h14; a += 4) do_load(8'(a), exp_read0(8'(a)));

        for (int k = 0; k < 4; k++) lo_cnt[k] = 0;
        repeat (300) begin
            if (!LED)   lo_cnt[0]++;
            if (!RGB_R) lo_cnt[1]++;
            if (!RGB_G) lo_cnt[2]++;
            if (!RGB_B) lo_cnt[3]++;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("idle_low_ch%0d", k), 32'(lo_cnt[k]), 32'd0);

        for (int v = 0; v < 9; v++) begin
            if (tbl[v].wr) do_store(tbl[v].waddr, tbl[v].wm, tbl[v].wd);
            do_load(tbl[v].raddr, tbl[v].exp);
        end

        wait_period_start();
        measure(-1, 8'h00, 32'h0);
        chk("p1_led_low", 32'(lo_cnt[0]), 32'd0);
        chk("p1_r_low",   32'(lo_cnt[1]), 32'd128);
        chk("p1_g_low",   32'(lo_cnt[2]), 32'd0);
        chk("p1_b_low",   32'(lo_cnt[3]), 32'd255);

        measure(99, 8'h08, 32'h40);
        chk("mid_g_cur_low", 32'(lo_cnt[2]), 32'd0);
        chk("mid_r_cur_low", 32'(lo_cnt[1]), 32'd128);
        measure(-1, 8'h00, 32'h0);
        chk("mid_g_next_low", 32'(lo_cnt[2]), 32'd64);

        do_store(8'h08, 4'h0, 32'h10);
        do_load(8'h08, 32'h40);
        do_store(8'h04, 4'h1, 32'h0);
        wait_period_start();
        measure(-1, 8'h00, 32'h0);
        chk("duty0_r_low", 32'(lo_cnt[1]), 32'd0);
        chk("keep_g_low",  32'(lo_cnt[2]), 32'd64);
        chk("keep_b_low",  32'(lo_cnt[3]), 32'd255);

        addr = 8'h08; wmask = 4'h1; wdata = 32'h22; wen = 1'b1; ren = 1'b1;
        sb_q.push_back(32'h40);
        sb_a.push_back(8'h08);
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        do_load(8'h08, 32'h22);
        repeat (3) @(negedge clk);
        chk("rdata_hold", rdata, 32'h22);

        do_store(8'h10, 4'hF, 32'hFFFF_FFFF);
        do_load(8'h10, exp_read0(8'h10));
        do_store(8'h14, 4'hF, 32'hFFFF_FFFF);
        do_load(8'h14, exp_read0(8'h14));

        do_store(8'h04, 4'h1, 32'h80);
        wait_period_start();
        repeat (100) @(negedge clk);
        addr = 8'h04;
        ren  = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_pins_now", 32'({LED, RGB_R, RGB_G, RGB_B}), 32'hF);
        chk("rst_rvalid_now", 32'(rvalid), 32'd0);
        ren = 1'b0;
        @(negedge clk);
        chk("rst_no_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_rvalid", 32'(rvalid), 32'd0);

        wait_cyc(11);
        do_load(8'h10, 32'd0);
        do_load(8'h10, 32'd1);
        do_load(8'h04, 32'd0);
        wait_period_start();
        measure(-1, 8'h00, 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("post_rst_low_ch%0d", k), 32'(lo_cnt[k]), 32'd0);

        wait_cyc(12000);
        do_load(8'h10, 32'd1000);
        do_load(8'h14, 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmio_led_pwm.md
Name: mmio_led_pwm

Overview:
- Memory-mapped output peripheral directly downstream of the RISC-V core's data-memory port.
- Consumes core load/store bus cycles decoded to its address window.
- Drives the board LED and RGB pins with 8-bit PWM.
- Exposes free-running microsecond and millisecond timers for firmware delays.

Parameters:
- CLK_HZ, 12000000: input clock frequency; sets the microsecond tick divisor (CLK_HZ/1000000, must be an integer ≥2).
- PWM_BITS, 8: duty and PWM counter width; PWM period = 2^PWM_BITS clocks.
- ACTIVE_LOW, 1: 1 means pins are driven low when a channel is on (iCE40 RGB sink outputs).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- addr  in  8  byte address within the peripheral window; bits [1:0] ignored
- wen  in  1  store strobe, one cycle per store
- wmask  in  4  byte enables for the store
- wdata  in  32  store data
- ren  in  1  load strobe, one cycle per load
- rdata  out  32  load data
- rvalid  out  1  load data valid pulse
- LED  out  1  PWM output, channel 0
- RGB_R  out  1  PWM output, channel 1
- RGB_G  out  1  PWM output, channel 2
- RGB_B  out  1  PWM output, channel 3

Behaviour:
- Register map (word offsets):
  - 0x00 LED_DUTY (RW)
  - 0x04 R_DUTY (RW)
  - 0x08 G_DUTY (RW)
  - 0x0C B_DUTY (RW)
  - 0x10 MICROS (RO, 32 bit)
  - 0x14 MILLIS (RO, 32 bit)
  - Every other offset reads 0 and ignores writes.
- Duty registers:
  - Store to a duty register updates duty[PWM_BITS-1:0] from wdata on the clock edge, but only if wmask[0]=1.
  - Upper wdata bits are discarded.
  - Readback returns the duty zero-extended to 32 bits.
- Stores to MICROS or MILLIS are ignored.
- Loads:
  - Read latency is exactly 1 cycle: rdata and rvalid are registered from the addr sampled with ren.
  - rvalid is high for exactly one cycle per ren.
  - rdata holds its last value when rvalid=0.
- Simultaneous wen and ren to the same address in one cycle: the load returns the pre-store value; the store still takes effect.
- PWM:
  - One shared counter pwm_cnt, PWM_BITS wide, increments every clock and wraps 2^PWM_BITS-1 to 0.
  - Each channel holds a shadow duty, loaded from its duty register only in the cycle pwm_cnt == 2^PWM_BITS-1. New duties take effect at the start of the next period, so there are no glitches mid-period.
  - Channel on = (pwm_cnt < shadow).
  - Duty 0 means always off. Duty 255 means on for 255 of 256 clocks.
  - Outputs are registered: 1-cycle delay from compare to pin.
  - Pin = on XOR ACTIVE_LOW.
- Timers:
  - A prescaler counts 0..CLK_HZ/1000000-1. At the terminal count it wraps and MICROS increments.
  - A sub-counter counts microsecond ticks 0..999. At 999, on a tick, it wraps and MILLIS increments in the same cycle.
  - Both timers wrap modulo 2^32 with no flag.
- Reset (asynchronous, any time, including mid-period or mid-load):
  - All duties, shadows, pwm_cnt, prescaler, sub-counter, MICROS, MILLIS, rdata and rvalid go to 0.
  - Pins go to the off level (1 when ACTIVE_LOW=1).
  - A load in flight at reset produces no rvalid.

Decomposition:
- Package mmio_led_pkg:
  - register offset constants (LED_DUTY_OFS..MILLIS_OFS)
  - NUM_CH=4
  - channel index enum (CH_LED, CH_R, CH_G, CH_B)
- Sub-module pwm_channel, instantiated 4x:
  - Inputs: duty, shared pwm_cnt, a period-end strobe.
  - Holds the shadow register and the registered output.
- The top of mmio_led_pwm holds the bus decode, the shared counters and the read mux.

Test Plan:
- Reset then idle 300 clocks -> all four pins stay 1; loads of 0x00..0x14 return 0 with rvalid one cycle after each ren.
- Store 0x80 to 0x04 with wmask=0001, wait for a period boundary, count R over 256 clocks -> pin low exactly 128 clocks, LED/G/B stay high; load 0x04 returns 0x00000080.
- Store 0x40 to 0x08 at mid-period (pwm_cnt=100) -> current period unchanged; the following period is low for 64 clocks. Store with wmask=0000 -> duty unchanged.
- Duty boundaries: duty 0 -> never low; duty 0xFF -> low 255 and high 1 per 256 clocks; wdata=0x1234_56FF stores 0xFF.
- Timers with CLK_HZ=12000000: after reset, 12000 clocks -> MICROS=1000, MILLIS=1; 11 clocks -> MICROS=0; store to 0x10 -> ignored.
- Assert rst mid-period with duty 0x80 and a pending ren -> pins go to 1 immediately; no rvalid; counters restart at 0 after release.
